seq_calc: RTL and testbench
===========================

SEQ_CALC -- requirements
Module: seq_calc

Interface
REQ-001 Parameter W, default 4, operand width in bits; legal range 2..16.
REQ-002 Parameter DIGITS, default 2, number of seven-segment digits displayed; legal range 1..6.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  synchronous reset, active-high; sampled on the rising edge of clk.
REQ-005 Port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 Port op  input  1  operation select, captured with start: 0 = multiply A*B, 1 = add A+B.
REQ-007 Port A  input  W  unsigned operand, captured with start.
REQ-008 Port B  input  W  unsigned operand, captured with start.
REQ-009 Port busy  output  1  high while an accepted operation is in progress.
REQ-010 Port done  output  1  single-cycle pulse marking the cycle in which new results are valid.
REQ-011 Port overflow  output  1  result does not fit in DIGITS decimal digits; held until the next done.
REQ-012 Port D  output  7*DIGITS  segment patterns: D[7i+6:7i] is decimal digit i (i=0 least significant); bit order gfedcba (bit0 = a); active-high.

Function
REQ-013 The FSM SHALL have the states IDLE, MUL, BCD and OUT, and SHALL leave IDLE only on a rising edge where start=1 and state=IDLE.
REQ-014 On acceptance, the block SHALL capture A, B and op into internal registers; changes to A, B or op afterwards SHALL have no effect on the running operation.
REQ-015 op=0: IDLE->MUL; the block SHALL compute the 2W-bit product in exactly W shift-add cycles, then MUL->BCD.
REQ-016 op=1: IDLE->BCD directly, loading the zero-extended sum A+B (W+1 bits, no truncation).
REQ-017 BCD: the block SHALL convert the 2W-bit result by shift-add-3 (double dabble) in exactly 2W cycles into enough internal BCD digits to hold 2^(2W)-1, then BCD->OUT.
REQ-018 OUT (one cycle): the block SHALL register D from the low DIGITS BCD digits, set overflow=1 iff any higher BCD digit is nonzero, and return to IDLE.
REQ-019 done SHALL be 1 in exactly the one cycle following the OUT edge; D and overflow SHALL be valid from that cycle on.
REQ-020 Latency from the accepting edge to the first cycle in which done=1: 3W+1 cycles for multiply, 2W+1 cycles for add.
REQ-021 busy SHALL be 1 from the cycle after the accepting edge up to and including the OUT cycle, and SHALL be 0 in the done cycle.
REQ-022 start while busy=1 SHALL be ignored, with no queuing.
REQ-023 start=1 during the done cycle SHALL be accepted, since the state is IDLE, allowing back-to-back operations.
REQ-024 On overflow, D SHALL show the low DIGITS digits of the true result modulo 10^DIGITS, with leading zeros displayed rather than blanked.
REQ-025 Digit encoding: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F (hex).
REQ-026 D and overflow SHALL change only at the OUT edge or on reset.

Reset
REQ-027 rst=1 at a clock edge SHALL force state IDLE, busy=0, done=0, overflow=0 and every digit of D to 7'h3F, from any state.
REQ-028 rst SHALL take priority over start at the same edge; an operation interrupted by reset SHALL produce no done pulse.
REQ-029 The first start accepted after rst deasserts SHALL behave identically to one issued from power-on reset.

Verification (W=4, DIGITS=2 unless stated)
REQ-030 A=15, B=15, op=0 -> done exactly 13 cycles after acceptance; D = {5B, 6D} ("25"); overflow=1.
REQ-031 A=0, B=15, op=0 and A=1, B=10, op=0 -> D = {3F, 3F} with overflow=0, then D = {06, 3F} with overflow=0.
REQ-032 A=9, B=8, op=1 -> done 9 cycles after acceptance; D = {06, 07} ("17"); overflow=0.
REQ-033 start pulsed while busy with different A and B -> ignored; the result matches the first operands and exactly one done pulse occurs.
REQ-034 rst asserted mid-MUL -> next cycle busy=0, D all 3F, no done pulse; a following A=3, B=4, op=0 -> D = {06, 5B} ("12").
REQ-035 W=8, DIGITS=3: A=255, B=255, op=0 -> done after 25 cycles; D = "025" = {3F, 5B, 6D}; overflow=1; a back-to-back start in the done cycle is accepted.

Source files
------------

// File: rtl/seq_calc.sv
// Sequential multiply/add calculator: shift-add multiplier, double-dabble
// binary-to-BCD conversion and registered seven-segment digit outputs.
module seq_calc #(
  parameter int unsigned W      = 4,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op,
  input  logic [W-1:0]          A,
  input  logic [W-1:0]          B,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   D
);

  // Decimal digits needed to represent 2^(2w)-1.
  function automatic int unsigned calc_digits(input int unsigned w);
    logic [63:0] v;
    int unsigned n;
    v = (64'd1 << (2 * w)) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        v = v / 64'd10;
        n++;
      end
    end
    return n;
  endfunction

  // One spare always-zero digit keeps the overflow slice non-empty.
  localparam int unsigned NMAX = calc_digits(W);
  localparam int unsigned NB   = ((NMAX > DIGITS) ? NMAX : DIGITS) + 1;
  localparam int unsigned CW   = $clog2(2 * W + 1);

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, MUL, BCD, OUT} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [2*W-1:0]        r_mcand;
  logic [W-1:0]          r_mplr;
  logic [2*W-1:0]        r_acc;
  logic [2*W-1:0]        r_bin;
  logic [4*NB-1:0]       r_bcd;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ovf;
  logic [7*DIGITS-1:0]   r_d;
  logic [2*W-1:0]        w_acc_nxt;
  logic [4*NB-1:0]       w_bcd_adj;
  logic [7*DIGITS-1:0]   w_d_nxt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start) w_state_nxt = op ? BCD : MUL;
      MUL:  if (r_cnt == CW'(W - 1)) w_state_nxt = BCD;
      BCD:  if (r_cnt == CW'(2 * W - 1)) w_state_nxt = OUT;
      OUT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_acc_nxt = r_acc + (r_mplr[0] ? r_mcand : '0);

  // Add-3 correction on every BCD digit that is 5 or more before the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < NB; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    w_d_nxt = '0;
    for (int i = 0; i < DIGITS; i++) w_d_nxt[7*i +: 7] = seg7(r_bcd[4*i +: 4]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_d     <= {DIGITS{7'h3F}};
      r_cnt   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_bin   <= '0;
      r_bcd   <= '0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (r_state == OUT);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand <= (2 * W)'(A);
            r_mplr  <= B;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_bin   <= op ? (2 * W)'({1'b0, A} + {1'b0, B}) : '0;
          end
        end
        MUL: begin
          r_acc   <= w_acc_nxt;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          if (r_cnt == CW'(W - 1)) begin
            r_bin <= w_acc_nxt;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        BCD: begin
          {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
          r_cnt          <= r_cnt + CW'(1);
        end
        OUT: begin
          r_d   <= w_d_nxt;
          r_ovf <= |r_bcd[4*NB-1:4*DIGITS];
        end
        default: ;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_ovf;
  assign D        = r_d;

endmodule

// File: tb/tb_seq_calc.sv
// Directed bench for seq_calc: a W=4/DIGITS=2 instance and a W=8/DIGITS=3 instance.
module tb_seq_calc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, op = 1'b0;
  logic [3:0]  a = '0, b = '0;
  logic        busy, done, ovf;
  logic [13:0] d;
  logic        start2 = 1'b0, op2 = 1'b0;
  logic [7:0]  a2 = '0, b2 = '0;
  logic        busy2, done2, ovf2;
  logic [20:0] d2;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  seq_calc #(.W(4), .DIGITS(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(a), .B(b),
    .busy(busy), .done(done), .overflow(ovf), .D(d)
  );

  seq_calc #(.W(8), .DIGITS(3)) u_dut_w8 (
    .clk(clk), .rst(rst), .start(start2), .op(op2), .A(a2), .B(b2),
    .busy(busy2), .done(done2), .overflow(ovf2), .D(d2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one operation on the W=4 instance; optionally poke start mid-run.
  task automatic run_op(input string tag, input logic [3:0] ia, input logic [3:0] ib,
                        input logic iop, input int exp_lat, input logic [13:0] exp_d,
                        input logic exp_ovf, input bit poke);
    int lat;
    start = 1'b1; a = ia; b = ib; op = iop;
    tick();
    start = 1'b0; a = ~ia; b = ~ib; op = ~iop;
    lat = 0;
    check({tag, ".busy_start"}, 32'(busy), 32'd1);
    while (!done && lat < 100) begin
      if (poke && lat == 3) begin
        start = 1'b1; a = 4'd15; b = 4'd15; op = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".D"}, 32'(d), 32'(exp_d));
    check({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    tick();
    check({tag, ".done_single"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    repeat (2) tick();
    rst = 1'b0;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.ovf", 32'(ovf), 32'd0);
    check("rst.D", 32'(d), 32'h1FBF);
    check("rst.D_w8", 32'(d2), {11'd0, {3{7'h3F}}});

    // Multiply, add and decimal boundaries.
    run_op("mul_15x15", 4'd15, 4'd15, 1'b0, 13, {7'h5B, 7'h6D}, 1'b1, 1'b0);
    run_op("mul_0x15",  4'd0,  4'd15, 1'b0, 13, {7'h3F, 7'h3F}, 1'b0, 1'b0);
    run_op("mul_1x10",  4'd1,  4'd10, 1'b0, 13, {7'h06, 7'h3F}, 1'b0, 1'b0);
    run_op("add_9p8",   4'd9,  4'd8,  1'b1, 9,  {7'h06, 7'h07}, 1'b0, 1'b0);
    run_op("add_15p15", 4'd15, 4'd15, 1'b1, 9,  {7'h4F, 7'h3F}, 1'b0, 1'b0);
    run_op("mul_9x11",  4'd9,  4'd11, 1'b0, 13, {7'h6F, 7'h6F}, 1'b0, 1'b0);
    run_op("mul_10x10", 4'd10, 4'd10, 1'b0, 13, {7'h3F, 7'h3F}, 1'b1, 1'b0);
    run_op("mul_7x6",   4'd7,  4'd6,  1'b0, 13, {7'h66, 7'h5B}, 1'b0, 1'b0);
    run_op("ignore",    4'd3,  4'd4,  1'b0, 13, {7'h06, 7'h5B}, 1'b0, 1'b1);
    run_op("mul_pre",   4'd15, 4'd15, 1'b0, 13, {7'h5B, 7'h6D}, 1'b1, 1'b0);

    // Reset in the middle of a multiply, then a clean operation.
    start = 1'b1; a = 4'd15; b = 4'd15; op = 1'b0;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.D", 32'(d), 32'h1FBF);
    check("midrst.ovf", 32'(ovf), 32'd0);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      if (done) pulses++;
      tick();
    end
    check("midrst.no_done", 32'(pulses), 32'd0);
    run_op("after_rst", 4'd3, 4'd4, 1'b0, 13, {7'h06, 7'h5B}, 1'b0, 1'b0);

    // Wide instance with a back-to-back start in the done cycle.
    start2 = 1'b1; a2 = 8'd255; b2 = 8'd255; op2 = 1'b0;
    tick();
    start2 = 1'b0; a2 = 8'd0; b2 = 8'd0;
    lat = 0;
    while (!done2 && lat < 100) begin
      tick();
      lat++;
    end
    check("w8.latency", 32'(lat), 32'd25);
    check("w8.D", 32'(d2), {11'd0, 7'h3F, 7'h5B, 7'h6D});
    check("w8.ovf", 32'(ovf2), 32'd1);
    start2 = 1'b1; a2 = 8'd2; b2 = 8'd3; op2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("w8.b2b_busy", 32'(busy2), 32'd1);
    lat = 0;
    while (!done2 && lat < 100) begin
      tick();
      lat++;
    end
    check("w8.b2b_latency", 32'(lat), 32'd17);
    check("w8.b2b_D", 32'(d2), {11'd0, 7'h3F, 7'h3F, 7'h6D});
    check("w8.b2b_ovf", 32'(ovf2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
